hex_display_ctrl: RTL and testbench
===================================

# hex_display_ctrl

Parametrised seven-segment display controller that replaces the fixed per-nibble hex decoders between the SoC conduit export and the HEX digit outputs. It captures a value on a write strobe and shows it in hex, or in decimal via an iterative binary-to-BCD engine. It also provides leading-zero blanking, per-digit blinking and an overflow indication. It sits in the board top level, fed directly by a PIO or conduit register.

## Interface
- DIGITS, 8: number of seven-segment digits driven; data width W = 4*DIGITS.
- CLK_HZ, 50_000_000: clk_clk frequency.
- BLINK_HZ, 2: blink rate (full on/off periods per second).
- clk_clk  in  1  system clock, one clock domain.
- reset_reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe; accepted when wr_en && wr_ready.
- wr_data  in  W  binary value to display.
- dec_mode  in  1  sampled with wr_en: 0 = hex, 1 = decimal.
- blank_lz  in  1  level: blank leading zero digits.
- blink_mask  in  DIGITS  level: bit i set makes digit i blink.
- wr_ready  out  1  high when a write can be accepted.
- hex_seg  out  7*DIGITS  active-low segments. Digit i is hex_seg[7*i +: 7], segment a at bit 7*i+6 down to g at bit 7*i.

## Operation
- FSM states: IDLE, CONV.
- IDLE, write with dec_mode=0: wr_data loads the display nibble register directly. Stay in IDLE.
- IDLE, write with dec_mode=1 and wr_data <= MAX_DEC (10^DIGITS-1): load the converter and go to CONV.
- IDLE, write with dec_mode=1 and wr_data > MAX_DEC: set the overflow flag with no conversion. All digits show a dash (segment g only) until the next accepted write. Stay in IDLE.
- CONV: one shift-and-add-3 step per cycle for W cycles. On the last step, commit the BCD result to the nibble register, clear overflow, return to IDLE.
- wr_ready = (state == IDLE). Writes presented in CONV are ignored, not queued.
- Glyphs: nibble 0-F uses standard hex shapes matching the existing hex7seg encoding. Blank = all segments off.
- Leading-zero blanking (blank_lz=1, overflow clear): zero digits above the most significant non-zero digit are blank. Digit 0 is never blanked, so value 0 shows "0".
- Blink: a prescaler counts to CLK_HZ/(2*BLINK_HZ)-1 and then toggles blink_phase. While blink_phase=1, masked digits are blank, including dash glyphs.
- Reset: state IDLE, nibble register 0, overflow 0, prescaler 0, blink_phase 0, wr_ready 1, hex_seg all 1 (all digits off).

## Timing
- Hex write accepted at edge N: nibble register updates at N; hex_seg shows the new value at edge N+1 (2-cycle latency from wr_en sample).
- Decimal write accepted at edge N: wr_ready low from N to N+W-1. Commit at edge N+W, wr_ready high after N+W, hex_seg updated at N+W+1.
- Overflow write: same 2-cycle latency as hex.
- blank_lz and blink_mask: registered into hex_seg, so a change is visible one cycle later.
- Blink edge: blink_phase toggles on the cycle the prescaler wraps; effect on hex_seg appears one cycle later.
- Reset asserted in CONV: conversion aborts, outputs return to reset values immediately, and no partial result is ever committed.
- A write in the same cycle as the commit is ignored, because wr_ready is still low.

## Structure
- Package hex_display_pkg holds:
  - the glyph constants (hex 0-F, DASH, BLANK);
  - function max_dec(DIGITS) returning 10^DIGITS-1 at W bits;
  - function clog2 for the prescaler width;
  - the state enum {IDLE, CONV}.
- Sub-module bin2bcd_seq (W-bit iterative double-dabble) has ports start, bin_in, busy, done and bcd_out. The top holds the FSM, the registers, the blink prescaler and the output glyph/blanking logic.

## Test plan
- Reset, then hex write 0x1234ABCD → hex_seg shows 1,2,3,4,A,B,C,D from digit 7 to digit 0, two cycles after the write; wr_ready stays 1.
- Decimal write 12345678 (DIGITS=8) → wr_ready low for 32 cycles, then digits read "12345678". A second write issued mid-conversion is ignored.
- Decimal write 100000000 → all eight digits show a dash after 2 cycles. A following hex write 0 clears it to "00000000".
- blank_lz=1, decimal write 42 → digits 7..2 blank, digits 1..0 show "42". Decimal write 0 → only digit 0 shows "0".
- CLK_HZ=20, BLINK_HZ=1, blink_mask=0x01 → digit 0 blank for 10 cycles, on for 10, repeating. Other digits stay steady.
- Assert reset 10 cycles into a decimal conversion → hex_seg all 1, wr_ready 1. After release, the nibble register is 0 and the next hex write displays correctly.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared constants and helpers for the seven-segment display controller.
// Glyphs are active-low with segment a in bit 6 down to segment g in bit 0.
package hex_display_pkg;

  typedef enum logic {IDLE, CONV} state_e;

  // Index n holds the shape for nibble value n.
  localparam logic [15:0][6:0] GLYPH_HEX = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };
  localparam logic [6:0] GLYPH_DASH  = 7'b1111110;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic logic [63:0] max_dec(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_bin2bcd_seq.sv
// Iterative double-dabble converter: one shift-and-add-3 step per clock, W steps.
// done and bcd_out present the final step combinationally so the caller commits on that edge.
module bin2bcd_seq
  import hex_display_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] bin_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] bcd_out
);

  localparam int CNT_W = clog2(W);

  logic [W-1:0]     r_bin;
  logic [W-1:0]     r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [W-1:0]     w_adj;
  logic [W-1:0]     w_bcd_next;
  logic [W-1:0]     w_bin_next;

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < W / 4; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  assign w_bcd_next = {w_adj[W-2:0], r_bin[W-1]};
  assign w_bin_next = {r_bin[W-2:0], 1'b0};

  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == CNT_W'(W - 1));
  assign bcd_out = w_bcd_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_bin  <= bin_in;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bin <= w_bin_next;
      r_bcd <= w_bcd_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Seven-segment controller: hex or decimal display of a written value with
// leading-zero blanking, per-digit blinking and an overflow dash indication.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic                  dec_mode,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic                  wr_ready,
  output logic [7*DIGITS-1:0]   hex_seg
);

  localparam int W         = 4 * DIGITS;
  localparam logic [W-1:0] MAX_DEC = W'(max_dec(DIGITS));
  localparam int PRESC_MAX = CLK_HZ / (2 * BLINK_HZ) - 1;
  localparam int PRESC_W   = (clog2(PRESC_MAX + 1) < 1) ? 1 : clog2(PRESC_MAX + 1);

  state_e               r_state;
  state_e               w_next_state;
  logic [W-1:0]         r_nib;
  logic                 r_ovf;
  logic [PRESC_W-1:0]   r_presc;
  logic                 r_blink_phase;
  logic                 w_accept;
  logic                 w_over_range;
  logic                 w_conv_start;
  logic                 w_conv_busy;
  logic                 w_conv_done;
  logic [W-1:0]         w_bcd;
  logic [7*DIGITS-1:0]  w_seg;

  assign wr_ready     = (r_state == IDLE);
  assign w_accept     = wr_en && wr_ready;
  assign w_over_range = (wr_data > MAX_DEC);
  assign w_conv_start = w_accept && dec_mode && !w_over_range;

  bin2bcd_seq #(.W(W)) u_bin2bcd (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .start   (w_conv_start),
    .bin_in  (wr_data),
    .busy    (w_conv_busy),
    .done    (w_conv_done),
    .bcd_out (w_bcd)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= IDLE;
    else                r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_conv_start) w_next_state = CONV;
      CONV: if (w_conv_done || !w_conv_busy) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // An out-of-range decimal write only raises overflow; the old digits stay underneath.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_nib <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept && !dec_mode) begin
      r_nib <= wr_data;
      r_ovf <= 1'b0;
    end else if (w_accept && w_over_range) begin
      r_ovf <= 1'b1;
    end else if (r_state == CONV && w_conv_done) begin
      r_nib <= w_bcd;
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_presc       <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_presc == PRESC_W'(PRESC_MAX)) begin
      r_presc       <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  // Walk from the top digit down; w_lead stays set while every digit so far is zero.
  always_comb begin
    logic       w_lead;
    logic [3:0] w_nib;
    logic [6:0] w_glyph;
    w_seg   = '1;
    w_lead  = 1'b1;
    w_nib   = '0;
    w_glyph = GLYPH_BLANK;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_nib  = r_nib[4*i +: 4];
      w_lead = w_lead && (w_nib == 4'd0);
      if (r_ovf)                             w_glyph = GLYPH_DASH;
      else if (blank_lz && w_lead && i != 0) w_glyph = GLYPH_BLANK;
      else                                   w_glyph = GLYPH_HEX[w_nib];
      if (r_blink_phase && blink_mask[i])    w_glyph = GLYPH_BLANK;
      w_seg[7*i +: 7] = w_glyph;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) hex_seg <= '1;
    else                hex_seg <= w_seg;
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl (8 digits, 20 Hz clock, 1 Hz blink) with a
// behavioural display model compared every cycle plus hand-computed glyph literals.
module tb_hex_display_ctrl;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        dec_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [7:0]  blink_mask = '0;
  logic        wr_ready;
  logic [55:0] hex_seg;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  hex_display_ctrl #(.DIGITS(8), .CLK_HZ(20), .BLINK_HZ(1)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .dec_mode      (dec_mode),
    .blank_lz      (blank_lz),
    .blink_mask    (blink_mask),
    .wr_ready      (wr_ready),
    .hex_seg       (hex_seg)
  );

  always #5 clk_clk = ~clk_clk;

  // Lit segments per nibble, active-high, a in bit 6 ... g in bit 0.
  localparam logic [6:0] SEG_ON [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                         7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  function automatic logic [55:0] expectedDisplay(input logic [31:0] nib, input logic ovf,
                                                  input logic lz, input logic [7:0] mask,
                                                  input logic phase);
    logic [55:0] res;
    logic [6:0]  g;
    int          msd;
    msd = 0;
    for (int i = 0; i < 8; i++) if (nib[4*i +: 4] != 4'd0) msd = i;
    for (int i = 0; i < 8; i++) begin
      if (phase && mask[i])    g = 7'h7F;
      else if (ovf)            g = ~7'h01;
      else if (lz && i > msd)  g = 7'h7F;
      else                     g = ~SEG_ON[nib[4*i +: 4]];
      res[7*i +: 7] = g;
    end
    return res;
  endfunction

  function automatic logic [31:0] toBcd(input int value);
    logic [31:0] r;
    int v;
    v = value;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  logic [31:0] mNib = '0;
  logic        mOvf = 1'b0;
  int          mConvLeft = 0;
  logic [31:0] mPending = '0;
  int          mPresc = 0;
  logic        mPhase = 1'b0;
  logic [55:0] mExpSeg = '1;
  logic        mExpReady = 1'b1;
  bit          mReadyNow;

  always @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mNib = '0; mOvf = 1'b0; mConvLeft = 0; mPresc = 0; mPhase = 1'b0;
      mExpSeg = '1; mExpReady = 1'b1;
    end else begin
      mExpSeg   = expectedDisplay(mNib, mOvf, blank_lz, blink_mask, mPhase);
      mReadyNow = (mConvLeft == 0);
      if (wr_en && mReadyNow) begin
        if (!dec_mode) begin
          mNib = wr_data; mOvf = 1'b0;
        end else if (wr_data > 32'd99999999) begin
          mOvf = 1'b1;
        end else begin
          mConvLeft = 32; mPending = toBcd(int'(wr_data));
        end
      end else if (mConvLeft > 0) begin
        mConvLeft--;
        if (mConvLeft == 0) begin
          mNib = mPending; mOvf = 1'b0;
        end
      end
      if (mPresc == 9) begin
        mPresc = 0; mPhase = ~mPhase;
      end else begin
        mPresc++;
      end
      mExpReady = (mConvLeft == 0);
    end
  end

  always @(negedge clk_clk) begin
    if (checkEn) begin
      checks++;
      if (hex_seg !== mExpSeg) begin
        errors++;
        $display("[TB] FAIL model hex_seg at %0t: got %h, expected %h", $time, hex_seg, mExpSeg);
      end
      checks++;
      if (wr_ready !== mExpReady) begin
        errors++;
        $display("[TB] FAIL model wr_ready at %0t: got %b, expected %b", $time, wr_ready, mExpReady);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [55:0] expSeg, input logic expReady);
    checks++;
    if (hex_seg !== expSeg || wr_ready !== expReady) begin
      errors++;
      $display("[TB] FAIL %s: hex_seg=%h wr_ready=%b, expected hex_seg=%h wr_ready=%b",
               name, hex_seg, wr_ready, expSeg, expReady);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic dec);
    @(negedge clk_clk);
    wr_en = 1'b1; wr_data = data; dec_mode = dec;
    @(negedge clk_clk);
    wr_en = 1'b0;
  endtask

  // Counts cycles with wr_ready low; optionally pokes a hex write at the tenth one.
  task automatic waitReady(output int lowCycles, input bit injectWrite);
    lowCycles = 0;
    while (!wr_ready && lowCycles < 40) begin
      lowCycles++;
      wr_en = injectWrite && (lowCycles == 10);
      wr_data = 32'hFFFF_FFFF; dec_mode = 1'b0;
      @(negedge clk_clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  localparam logic [55:0] LIT_1234ABCD = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                          7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010};
  localparam logic [55:0] LIT_12345678 = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                          7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000};
  localparam logic [55:0] LIT_DASHES   = {8{7'b1111110}};
  localparam logic [55:0] LIT_ZEROS    = {8{7'b0000001}};
  localparam logic [55:0] LIT_LZ42     = {{6{7'b1111111}}, 7'b1001100, 7'b0010010};
  localparam logic [55:0] LIT_LZ0      = {{7{7'b1111111}}, 7'b0000001};
  localparam logic [55:0] LIT_C0FFEE00 = {7'b0110001, 7'b0000001, 7'b0111000, 7'b0111000,
                                          7'b0110000, 7'b0110000, 7'b0000001, 7'b0000001};

  initial begin
    int lowCycles;
    bit blankNow;
    bit blankPrev;
    int trans[$];

    repeat (3) @(negedge clk_clk);
    checkOutput("resetState", '1, 1'b1);
    reset_reset_n = 1'b1;
    checkEn = 1'b1;

    applyStimulus(32'h1234_ABCD, 1'b0);
    @(negedge clk_clk);
    checkOutput("hexWrite", LIT_1234ABCD, 1'b1);

    applyStimulus(32'd12345678, 1'b1);
    waitReady(lowCycles, 1'b1);
    checkCount("convBusyCycles", lowCycles, 32);
    @(negedge clk_clk);
    checkOutput("decWrite", LIT_12345678, 1'b1);

    applyStimulus(32'd100000000, 1'b1);
    @(negedge clk_clk);
    checkOutput("overflowDash", LIT_DASHES, 1'b1);
    applyStimulus(32'h0, 1'b0);
    @(negedge clk_clk);
    checkOutput("overflowClear", LIT_ZEROS, 1'b1);

    blank_lz = 1'b1;
    applyStimulus(32'd42, 1'b1);
    waitReady(lowCycles, 1'b0);
    @(negedge clk_clk);
    checkOutput("lzBlank42", LIT_LZ42, 1'b1);
    applyStimulus(32'd0, 1'b1);
    waitReady(lowCycles, 1'b0);
    @(negedge clk_clk);
    checkOutput("lzBlankZero", LIT_LZ0, 1'b1);
    blank_lz = 1'b0;

    applyStimulus(32'h1234_5678, 1'b0);
    blink_mask = 8'h01;
    @(negedge clk_clk);
    blankPrev = (hex_seg[6:0] == 7'h7F);
    for (int k = 1; k < 45; k++) begin
      @(negedge clk_clk);
      blankNow = (hex_seg[6:0] == 7'h7F);
      if (blankNow != blankPrev) trans.push_back(k);
      blankPrev = blankNow;
    end
    checks++;
    if (trans.size() < 3) begin
      errors++;
      $display("[TB] FAIL blinkToggles: got %0d transitions, expected at least 3", trans.size());
    end else begin
      checkCount("blinkRun1", trans[1] - trans[0], 10);
      checkCount("blinkRun2", trans[2] - trans[1], 10);
    end
    blink_mask = 8'h00;

    applyStimulus(32'd12345678, 1'b1);
    repeat (9) @(negedge clk_clk);
    #2 reset_reset_n = 1'b0;
    #1 checkOutput("resetMidConv", '1, 1'b1);
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);
    checkOutput("afterResetZero", LIT_ZEROS, 1'b1);
    applyStimulus(32'hC0FF_EE00, 1'b0);
    @(negedge clk_clk);
    checkOutput("afterResetHex", LIT_C0FFEE00, 1'b1);
    repeat (40) @(negedge clk_clk);

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
